// File: rtl/cmp_result_monitor_pkg.sv
// ----------------------------------------------------------------------------
// cmp_mon_pkg
// Purpose : shared types and constants for the comparator result monitor.
//           Holds the result-code encodings, the FSM state encodings and the
//           helpers that classify and encode a one-hot {gt,eq,lt} sample.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package cmp_mon_pkg;

  typedef logic [1:0] code_t;

  // 00 is reserved as "no code"; it is never emitted on the event stream.
  localparam code_t CODE_NONE = 2'b00;
  localparam code_t CODE_GT   = 2'b01;
  localparam code_t CODE_EQ   = 2'b10;
  localparam code_t CODE_LT   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no open run
    ST_RUN  = 1'b1   // run_code/run_len describe the open run
  } state_t;

  // Exactly one of the three flags set.
  function automatic logic is_one_hot(input logic gt, input logic eq, input logic lt);
    return (gt ^ eq ^ lt) & ~(gt & eq & lt);
  endfunction

  // Only meaningful for one-hot inputs; anything else maps to CODE_NONE.
  function automatic code_t onehot_to_code(input logic gt, input logic eq, input logic lt);
    code_t code;
    code = CODE_NONE;
    if (is_one_hot(gt, eq, lt)) begin
      if (gt)      code = CODE_GT;
      else if (eq) code = CODE_EQ;
      else         code = CODE_LT;
    end
    return code;
  endfunction

endpackage

// File: rtl/cmp_result_monitor_if.sv
// ----------------------------------------------------------------------------
// cmp_result_monitor_if
// Purpose : bundles the monitor's input sample stream, output event stream
//           and status outputs.
// Signals : in_valid/in_ready/gt/eq/lt/flush  - comparator result stream
//           evt_valid/evt_ready/evt_code/evt_len - run-length event stream
//           alarm, err, cnt_gt/cnt_eq/cnt_lt   - status and tallies
// Modports: slave  - the monitor itself
//           master - the environment driving samples and consuming events
// ----------------------------------------------------------------------------
interface cmp_result_monitor_if #(
  parameter int RUN_W = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             flush;
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_code;
  logic [RUN_W-1:0] evt_len;
  logic             alarm;
  logic             err;
  logic [CNT_W-1:0] cnt_gt;
  logic [CNT_W-1:0] cnt_eq;
  logic [CNT_W-1:0] cnt_lt;

  modport slave (
    input  in_valid, gt, eq, lt, flush, evt_ready,
    output in_ready, evt_valid, evt_code, evt_len, alarm, err,
           cnt_gt, cnt_eq, cnt_lt
  );

  modport master (
    output in_valid, gt, eq, lt, flush, evt_ready,
    input  in_ready, evt_valid, evt_code, evt_len, alarm, err,
           cnt_gt, cnt_eq, cnt_lt
  );
endinterface

// File: rtl/cmp_result_monitor_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Purpose : W-bit up-counter that sticks at all-ones instead of wrapping,
//           with a synchronous load that takes priority over increment.
// Ports   : clk, rst       - clock, asynchronous active-high reset (q -> 0)
//           i_inc          - increment by one unless already saturated
//           i_clr_load     - load i_load_val (use 0 to clear)
//           i_load_val     - value loaded by i_clr_load
//           o_q            - current count
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clr_load) begin
      r_q <= i_load_val;
    end else if (i_inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cmp_result_monitor.sv
// ----------------------------------------------------------------------------
// cmp_result_monitor
// Purpose : consumes the one-hot gt/eq/lt result stream of the 4-bit
//           comparator, run-length encodes consecutive identical results into
//           {code,len} events, raises a level alarm while an open GT run is at
//           or above RUN_THRESH, and latches a sticky error on any accepted
//           non-one-hot sample.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           mon  - cmp_result_monitor_if.slave (sample stream, event stream,
//                  alarm, err, per-code tallies)
// Config  : define CMP_MON_STATS_EN to build the saturating per-code tallies;
//           without it cnt_gt/cnt_eq/cnt_lt are tied to zero.
// ----------------------------------------------------------------------------
module cmp_result_monitor
  import cmp_mon_pkg::*;
#(
  parameter int RUN_W      = 4,
  parameter int RUN_THRESH = 3,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cmp_result_monitor_if.slave  mon
);

  state_t           r_state;
  state_t           w_state_next;
  code_t            r_run_code;
  logic [RUN_W-1:0] w_run_len;

  logic             r_evt_valid;
  code_t            r_evt_code;
  logic [RUN_W-1:0] r_evt_len;
  logic             r_err;

  logic             w_in_ready;
  logic             w_alarm;
  logic             w_accept;
  logic             w_legal;
  code_t            w_code;
  logic             w_sample;
  logic             w_flush;
  logic             w_in_run;
  logic             w_emit;
  logic             w_run_load;
  logic             w_run_inc;
  logic [RUN_W-1:0] w_run_load_val;

  // --------------------------------------------------------------------------
  // Input classification
  // --------------------------------------------------------------------------
  assign w_accept = mon.in_valid & w_in_ready;
  assign w_legal  = is_one_hot(mon.gt, mon.eq, mon.lt);
  assign w_code   = onehot_to_code(mon.gt, mon.eq, mon.lt);
  assign w_sample = w_accept & w_legal;
  // flush is gated by in_ready so it can never overwrite a pending event.
  assign w_flush  = mon.flush & w_in_ready;
  assign w_in_run = (r_state == ST_RUN);

  // The open run closes on flush, or on a legal sample with a new code.
  assign w_emit = w_in_run & (w_flush | (w_sample & (w_code != r_run_code)));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_sample) w_state_next = ST_RUN;
      ST_RUN: begin
        // A sample in the flush cycle opens a fresh run after the flush.
        if (w_sample)     w_state_next = ST_RUN;
        else if (w_flush) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs decoded from registers
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_ready = ~r_evt_valid | mon.evt_ready;
    w_alarm    = w_in_run && (r_run_code == CODE_GT) &&
                 (w_run_len >= RUN_W'(RUN_THRESH));
  end

  // --------------------------------------------------------------------------
  // Open run: code register and saturating length counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_code <= CODE_NONE;
    end else if (w_sample) begin
      r_run_code <= w_code;
    end
  end

  // Load 1 whenever a sample starts a new run (from IDLE, after a code
  // change, or after a flush even with the same code); load 0 when a flush
  // closes the run with nothing to follow it.
  assign w_run_load     = (w_sample & (~w_in_run | w_emit)) | (w_flush & w_in_run);
  assign w_run_load_val = w_sample ? RUN_W'(1) : '0;
  assign w_run_inc      = w_sample & w_in_run & ~w_emit;

  sat_counter #(.W(RUN_W)) u_run_len (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_run_inc),
    .i_clr_load (w_run_load),
    .i_load_val (w_run_load_val),
    .o_q        (w_run_len)
  );

  // --------------------------------------------------------------------------
  // Event output register. A new event may load in the same cycle the
  // previous one is taken, since in_ready is then high via evt_ready.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_code  <= CODE_NONE;
      r_evt_len   <= '0;
    end else if (w_emit) begin
      r_evt_valid <= 1'b1;
      r_evt_code  <= r_run_code;
      r_evt_len   <= w_run_len;
    end else if (mon.evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  // Sticky malformed-sample flag; the sample itself is otherwise ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept & ~w_legal) begin
      r_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Optional per-code tallies (index 0..2 -> GT, EQ, LT)
  // --------------------------------------------------------------------------
`ifdef CMP_MON_STATS_EN
  logic [CNT_W-1:0] w_stat_q [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    sat_counter #(.W(CNT_W)) u_stat (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (w_sample & (w_code == code_t'(gi + 1))),
      .i_clr_load (1'b0),
      .i_load_val ({CNT_W{1'b0}}),
      .o_q        (w_stat_q[gi])
    );
  end

  assign mon.cnt_gt = w_stat_q[0];
  assign mon.cnt_eq = w_stat_q[1];
  assign mon.cnt_lt = w_stat_q[2];
`else
  assign mon.cnt_gt = {CNT_W{1'b0}};
  assign mon.cnt_eq = {CNT_W{1'b0}};
  assign mon.cnt_lt = {CNT_W{1'b0}};
`endif

  assign mon.in_ready  = w_in_ready;
  assign mon.evt_valid = r_evt_valid;
  assign mon.evt_code  = r_evt_code;
  assign mon.evt_len   = r_evt_len;
  assign mon.alarm     = w_alarm;
  assign mon.err       = r_err;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// ----------------------------------------------------------------------------
// tb_cmp_result_monitor
// Purpose : directed self-checking bench for cmp_result_monitor. Inputs change
//           on the falling edge; outputs are checked 1 time unit after the
//           rising edge (or mid-cycle for combinational/async behaviour).
// ----------------------------------------------------------------------------
module tb_cmp_result_monitor;

  localparam int RUN_W = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cmp_result_monitor_if #(.RUN_W(RUN_W), .CNT_W(CNT_W)) mon ();

  cmp_result_monitor #(.RUN_W(RUN_W), .RUN_THRESH(3), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and return 1 time unit after the edge.
  task automatic drive(input logic v, input logic g, input logic e,
                       input logic l, input logic f);
    @(negedge clk);
    mon.in_valid = v;
    mon.gt       = g;
    mon.eq       = e;
    mon.lt       = l;
    mon.flush    = f;
    @(posedge clk);
    #1;
    mon.in_valid = 1'b0;
    mon.gt       = 1'b0;
    mon.eq       = 1'b0;
    mon.lt       = 1'b0;
    mon.flush    = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (mon.evt_valid !== 1'b0 || mon.evt_code !== 2'b00 || mon.evt_len !== 4'd0 ||
        mon.alarm !== 1'b0 || mon.err !== 1'b0 || mon.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: evt_valid=%b code=%b len=%0d alarm=%b err=%b in_ready=%b required 0,00,0,0,0,1",
               mon.evt_valid, mon.evt_code, mon.evt_len, mon.alarm, mon.err, mon.in_ready);
    end
    checks++;
    if (mon.cnt_gt !== 8'd0 || mon.cnt_eq !== 8'd0 || mon.cnt_lt !== 8'd0) begin
      failures++;
      $display("FAIL reset_counters: gt=%0d eq=%0d lt=%0d required 0", mon.cnt_gt, mon.cnt_eq, mon.cnt_lt);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_gt_alarm;
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    checks++;
    if (mon.alarm !== 1'b0) begin
      failures++;
      $display("FAIL alarm_below_thresh: alarm=%b required 0", mon.alarm);
    end
    drive(1, 1, 0, 0, 0);
    checks++;
    if (mon.alarm !== 1'b1 || mon.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL alarm_at_thresh: alarm=%b evt_valid=%b required 1,0", mon.alarm, mon.evt_valid);
    end
    drive(1, 0, 1, 0, 0);
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b01 || mon.evt_len !== 4'd3 || mon.alarm !== 1'b0) begin
      failures++;
      $display("FAIL gt_run_event: valid=%b code=%b len=%0d alarm=%b required 1,01,3,0",
               mon.evt_valid, mon.evt_code, mon.evt_len, mon.alarm);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b10 || mon.evt_len !== 4'd1) begin
      failures++;
      $display("FAIL eq_flush_event: valid=%b code=%b len=%0d required 1,10,1",
               mon.evt_valid, mon.evt_code, mon.evt_len);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (mon.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL event_consumed: evt_valid=%b required 0", mon.evt_valid);
    end
    $display("test_gt_alarm done");
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 17; i++) drive(1, 0, 1, 0, 0);
    checks++;
    if (mon.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL sat_no_event: evt_valid=%b required 0", mon.evt_valid);
    end
    drive(1, 0, 0, 1, 0);
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b10 || mon.evt_len !== 4'd15) begin
      failures++;
      $display("FAIL sat_event: valid=%b code=%b len=%0d required 1,10,15",
               mon.evt_valid, mon.evt_code, mon.evt_len);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b11 || mon.evt_len !== 4'd1) begin
      failures++;
      $display("FAIL sat_followup: valid=%b code=%b len=%0d required 1,11,1",
               mon.evt_valid, mon.evt_code, mon.evt_len);
    end
    drive(0, 0, 0, 0, 0);
    $display("test_saturation done");
  endtask

  task automatic test_backpressure;
    mon.evt_ready = 1'b0;
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    @(negedge clk);
    mon.in_valid = 1'b1;
    mon.lt       = 1'b1;
    #1;
    checks++;
    if (mon.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_in_ready: in_ready=%b required 0", mon.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b01 || mon.evt_len !== 4'd1) begin
      failures++;
      $display("FAIL stall_hold: valid=%b code=%b len=%0d required 1,01,1",
               mon.evt_valid, mon.evt_code, mon.evt_len);
    end
    @(negedge clk);
    mon.evt_ready = 1'b1;
    #1;
    checks++;
    if (mon.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_in_ready: in_ready=%b required 1", mon.in_ready);
    end
    @(posedge clk);
    #1;
    mon.in_valid = 1'b0;
    mon.lt       = 1'b0;
    // Held LT closes the EQ run while the GT event is taken in the same edge.
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b10 || mon.evt_len !== 4'd1) begin
      failures++;
      $display("FAIL back_to_back: valid=%b code=%b len=%0d required 1,10,1",
               mon.evt_valid, mon.evt_code, mon.evt_len);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b11 || mon.evt_len !== 4'd1) begin
      failures++;
      $display("FAIL held_sample_run: valid=%b code=%b len=%0d required 1,11,1",
               mon.evt_valid, mon.evt_code, mon.evt_len);
    end
    drive(0, 0, 0, 0, 0);
    $display("test_backpressure done");
  endtask

  task automatic test_illegal;
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    checks++;
    if (mon.err !== 1'b1 || mon.evt_valid !== 1'b0 || mon.alarm !== 1'b0) begin
      failures++;
      $display("FAIL illegal_sample: err=%b evt_valid=%b alarm=%b required 1,0,0",
               mon.err, mon.evt_valid, mon.alarm);
    end
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    checks++;
    if (mon.alarm !== 1'b1 || mon.err !== 1'b1) begin
      failures++;
      $display("FAIL run_after_illegal: alarm=%b err=%b required 1,1", mon.alarm, mon.err);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b01 || mon.evt_len !== 4'd3 || mon.err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_run_event: valid=%b code=%b len=%0d err=%b required 1,01,3,1",
               mon.evt_valid, mon.evt_code, mon.evt_len, mon.err);
    end
    drive(0, 0, 0, 0, 0);
    $display("test_illegal done");
  endtask

  task automatic test_same_code_flush;
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1);
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b01 || mon.evt_len !== 4'd1) begin
      failures++;
      $display("FAIL same_code_flush: valid=%b code=%b len=%0d required 1,01,1",
               mon.evt_valid, mon.evt_code, mon.evt_len);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b01 || mon.evt_len !== 4'd1) begin
      failures++;
      $display("FAIL new_run_len1: valid=%b code=%b len=%0d required 1,01,1",
               mon.evt_valid, mon.evt_code, mon.evt_len);
    end
    drive(0, 0, 0, 0, 0);
    $display("test_same_code_flush done");
  endtask

  task automatic test_flush;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b11 || mon.evt_len !== 4'd2) begin
      failures++;
      $display("FAIL flush_event: valid=%b code=%b len=%0d required 1,11,2",
               mon.evt_valid, mon.evt_code, mon.evt_len);
    end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    checks++;
    if (mon.evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_flush: evt_valid=%b required 0", mon.evt_valid);
    end
`ifdef CMP_MON_STATS_EN
    checks++;
    if (mon.cnt_lt !== 8'd2 || mon.cnt_gt !== 8'd0 || mon.cnt_eq !== 8'd0) begin
      failures++;
      $display("FAIL stats: gt=%0d eq=%0d lt=%0d required 0,0,2", mon.cnt_gt, mon.cnt_eq, mon.cnt_lt);
    end
`else
    checks++;
    if (mon.cnt_lt !== 8'd0 || mon.cnt_gt !== 8'd0 || mon.cnt_eq !== 8'd0) begin
      failures++;
      $display("FAIL stats_off: gt=%0d eq=%0d lt=%0d required 0,0,0", mon.cnt_gt, mon.cnt_eq, mon.cnt_lt);
    end
`endif
    $display("test_flush done");
  endtask

  task automatic test_reset_midrun;
    drive(1, 0, 0, 0, 0);  // set err again
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    mon.evt_ready = 1'b0;
    drive(1, 0, 1, 0, 0);
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.err !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_state: evt_valid=%b err=%b required 1,1", mon.evt_valid, mon.err);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (mon.evt_valid !== 1'b0 || mon.err !== 1'b0 || mon.alarm !== 1'b0 || mon.in_ready !== 1'b1 ||
        mon.evt_code !== 2'b00 || mon.evt_len !== 4'd0) begin
      failures++;
      $display("FAIL midrun_reset: valid=%b err=%b alarm=%b in_ready=%b code=%b len=%0d required 0,0,0,1,00,0",
               mon.evt_valid, mon.err, mon.alarm, mon.in_ready, mon.evt_code, mon.evt_len);
    end
    @(negedge clk);
    rst = 1'b0;
    mon.evt_ready = 1'b1;
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    checks++;
    if (mon.evt_valid !== 1'b1 || mon.evt_code !== 2'b10 || mon.evt_len !== 4'd1) begin
      failures++;
      $display("FAIL run_discarded: valid=%b code=%b len=%0d required 1,10,1",
               mon.evt_valid, mon.evt_code, mon.evt_len);
    end
    drive(0, 0, 0, 0, 0);
    $display("test_reset_midrun done");
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    mon.in_valid  = 1'b0;
    mon.gt        = 1'b0;
    mon.eq        = 1'b0;
    mon.lt        = 1'b0;
    mon.flush     = 1'b0;
    mon.evt_ready = 1'b1;
    test_reset();
    test_gt_alarm();
    test_saturation();
    test_backpressure();
    test_illegal();
    test_same_code_flush();
    test_flush();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
